pipe_scroller: RTL and testbench

Parametrised N-pipe obstacle generator and scroller for the Flappy-style game datapath. Holds X/Y for NUM_PIPES pipes, seeds each gap height from the shared random source, scrolls all pipes left at a programmable speed on a divided tick, and respawns any pipe that leaves the screen behind its ring predecessor. It sits between the random-number source and the renderer and collision logic. It adds speed control, pause, Y clamping, a valid mask and an optional score counter.

---
 rtl/pipe_scroller_if.sv | 32 +++
 rtl/pipe_scroller.sv | 190 +++++++++++++++++++
 tb/tb_pipe_scroller.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_scroller_if.sv
// ---------------------------------------------------------------------------
// pipe_scroller_if
// Bundles the game-state / random / speed inputs and the per-pipe outputs of
// pipe_scroller.
//   master : game controller side (drives iState, iRandomNumber, iSpeed)
//   slave  : pipe_scroller side (drives oPipeX, oPipeY, oValid, oRespawn,
//            oScore)
// Per-pipe vectors pack pipe i at bits [i*COORD_W +: COORD_W].
// ---------------------------------------------------------------------------
interface pipe_scroller_if #(
   parameter int NUM_PIPES = 3,
   parameter int COORD_W   = 32
);
   logic        [1:0]                   iState;
   logic signed [COORD_W-1:0]           iRandomNumber;
   logic        [3:0]                   iSpeed;
   logic        [NUM_PIPES*COORD_W-1:0] oPipeX;
   logic        [NUM_PIPES*COORD_W-1:0] oPipeY;
   logic        [NUM_PIPES-1:0]         oValid;
   logic                                oRespawn;
   logic        [15:0]                  oScore;

   modport master (
      output iState, iRandomNumber, iSpeed,
      input  oPipeX, oPipeY, oValid, oRespawn, oScore
   );

   modport slave (
      input  iState, iRandomNumber, iSpeed,
      output oPipeX, oPipeY, oValid, oRespawn, oScore
   );
endinterface

// File: rtl/pipe_scroller.sv
// ---------------------------------------------------------------------------
// pipe_scroller
// Ring of NUM_PIPES obstacles: seeds gap heights from the shared random
// source, scrolls every pipe left by iSpeed on each divided tick and respawns
// a pipe that has left the screen PIPE_DISTANCE behind its ring predecessor.
// Ports:
//   iClock   : system clock, rising edge
//   iResetN  : asynchronous active-low reset
//   bus      : pipe_scroller_if.slave
//              iState 0 idle / 1 run / 2,3 pause, iRandomNumber, iSpeed in;
//              oPipeX/oPipeY packed per pipe, oValid, oRespawn, oScore out
// Optional feature macro: PIPE_SCROLLER_SCORE_EN builds the pass counter
// (oScore); without it oScore is constant zero.
// ---------------------------------------------------------------------------
module pipe_scroller #(
   parameter int NUM_PIPES     = 3,
   parameter int COORD_W       = 32,
   parameter int SCREEN_WIDTH  = 640,
   parameter int PIPE_WIDTH    = 52,
   parameter int PIPE_DISTANCE = 275,
   parameter int Y_MIN         = 50,
   parameter int Y_MAX         = 330,
   parameter int TICK_DIV      = 50000,
   parameter int BIRD_X        = 100
)(
   input logic            iClock,
   input logic            iResetN,
   pipe_scroller_if.slave bus
);
   localparam int TIMER_W = $clog2(TICK_DIV);

   typedef logic signed [COORD_W-1:0] coord_t;

   localparam logic [TIMER_W-1:0] TICK_LAST = TIMER_W'(TICK_DIV - 1);
   localparam coord_t Y_MIN_C   = coord_t'(Y_MIN);
   localparam coord_t Y_MAX_C   = coord_t'(Y_MAX);
   localparam coord_t X_LIMIT   = coord_t'(-PIPE_WIDTH);
   localparam coord_t DIST_C    = coord_t'(PIPE_DISTANCE);
   localparam coord_t NO_Y      = coord_t'(-1);

   function automatic coord_t clamp_y(input coord_t r);
      if (r < Y_MIN_C)
         return Y_MIN_C;
      else if (r > Y_MAX_C)
         return Y_MAX_C;
      else
         return r;
   endfunction

   function automatic coord_t start_x(input int i);
      return coord_t'(SCREEN_WIDTH + i * PIPE_DISTANCE);
   endfunction

   coord_t                 x_reg   [NUM_PIPES];
   coord_t                 y_reg   [NUM_PIPES];
   coord_t                 x_moved [NUM_PIPES];
   coord_t                 x_next  [NUM_PIPES];
   logic [NUM_PIPES-1:0]   valid_reg;
   logic [NUM_PIPES-1:0]   seed_sel;
   logic [NUM_PIPES-1:0]   spawn_sel;
   logic [TIMER_W-1:0]     timer_reg;
   logic [TIMER_W-1:0]     timer_next;
   logic                   tick;
   logic                   respawn_reg;
   coord_t                 rand_y;
   coord_t                 speed_ext;

   assign rand_y    = clamp_y(bus.iRandomNumber);
   assign speed_ext = coord_t'(bus.iSpeed);

   always_comb begin
      tick       = (timer_reg == TICK_LAST);
      timer_next = tick ? '0 : timer_reg + TIMER_W'(1);
   end

   // One-hot pick of the lowest invalid pipe (seeding) and, only when nothing
   // is being seeded, the lowest off-screen pipe (respawn).
   always_comb begin
      logic seed_found;
      logic spawn_found;
      seed_sel    = '0;
      spawn_sel   = '0;
      seed_found  = 1'b0;
      spawn_found = 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
         if (!valid_reg[i] && !seed_found) begin
            seed_sel[i] = 1'b1;
            seed_found  = 1'b1;
         end
      end
      for (int i = 0; i < NUM_PIPES; i++) begin
         if (!seed_found && !spawn_found && (x_reg[i] < X_LIMIT)) begin
            spawn_sel[i] = 1'b1;
            spawn_found  = 1'b1;
         end
      end
   end

   // The respawned pipe lands behind its predecessor's post-move position;
   // the predecessor never respawns in the same cycle, so x_moved is final.
   always_comb begin
      for (int i = 0; i < NUM_PIPES; i++) begin
         x_moved[i] = tick ? x_reg[i] - speed_ext : x_reg[i];
      end
      for (int i = 0; i < NUM_PIPES; i++) begin
         if (spawn_sel[i])
            x_next[i] = x_moved[(i + NUM_PIPES - 1) % NUM_PIPES] + DIST_C;
         else
            x_next[i] = x_moved[i];
      end
   end

   always_ff @(posedge iClock or negedge iResetN) begin
      if (!iResetN) begin
         for (int i = 0; i < NUM_PIPES; i++) begin
            x_reg[i] <= start_x(i);
            y_reg[i] <= (i == 0) ? Y_MIN_C : NO_Y;
         end
         valid_reg   <= NUM_PIPES'(1);
         timer_reg   <= '0;
         respawn_reg <= 1'b0;
      end else begin
         case (bus.iState)
            2'd0: begin
               for (int i = 0; i < NUM_PIPES; i++) begin
                  x_reg[i] <= start_x(i);
                  y_reg[i] <= (i == 0) ? rand_y : NO_Y;
               end
               valid_reg   <= NUM_PIPES'(1);
               timer_reg   <= '0;
               respawn_reg <= 1'b0;
            end
            2'd1: begin
               for (int i = 0; i < NUM_PIPES; i++) begin
                  x_reg[i] <= x_next[i];
                  if (seed_sel[i] || spawn_sel[i])
                     y_reg[i] <= rand_y;
               end
               valid_reg   <= valid_reg | seed_sel;
               timer_reg   <= timer_next;
               respawn_reg <= |spawn_sel;
            end
            default: begin
               respawn_reg <= 1'b0;
            end
         endcase
      end
   end

`ifdef PIPE_SCROLLER_SCORE_EN
   localparam coord_t BIRD_X_C = coord_t'(BIRD_X);

   logic [15:0] score_reg;
   logic [16:0] score_sum;

   // At most NUM_PIPES (<= 8) crossings per tick, so bit 16 flags overflow.
   always_comb begin
      score_sum = {1'b0, score_reg};
      if (tick) begin
         for (int i = 0; i < NUM_PIPES; i++) begin
            if (!spawn_sel[i] && (x_reg[i] >= BIRD_X_C) && (x_moved[i] < BIRD_X_C))
               score_sum = score_sum + 17'd1;
         end
      end
   end

   always_ff @(posedge iClock or negedge iResetN) begin
      if (!iResetN)
         score_reg <= '0;
      else if (bus.iState == 2'd0)
         score_reg <= '0;
      else if (bus.iState == 2'd1)
         score_reg <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
   end

   assign bus.oScore = score_reg;
`else
   assign bus.oScore = '0;
`endif

   generate
      for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_pack
         assign bus.oPipeX[gi*COORD_W +: COORD_W] = x_reg[gi];
         assign bus.oPipeY[gi*COORD_W +: COORD_W] = y_reg[gi];
      end
   endgenerate

   assign bus.oValid   = valid_reg;
   assign bus.oRespawn = respawn_reg;
endmodule

// File: tb/tb_pipe_scroller.sv
// ---------------------------------------------------------------------------
// tb_pipe_scroller
// Self-checking bench for pipe_scroller (NUM_PIPES=3, TICK_DIV=4). Directed
// scenarios use hand-derived constants; the randomized run compares every
// output each cycle against a behavioural model of the game rules.
// ---------------------------------------------------------------------------
module tb_pipe_scroller;
   localparam int N   = 3;
   localparam int CW  = 32;
   localparam int SW  = 640;
   localparam int PW  = 52;
   localparam int PD  = 275;
   localparam int YMN = 50;
   localparam int YMX = 330;
   localparam int TD  = 4;
   localparam int BX  = 100;

   logic iClock  = 1'b0;
   logic iResetN = 1'b1;

   pipe_scroller_if #(.NUM_PIPES(N), .COORD_W(CW)) bus ();

   pipe_scroller #(
      .NUM_PIPES(N), .COORD_W(CW), .SCREEN_WIDTH(SW), .PIPE_WIDTH(PW),
      .PIPE_DISTANCE(PD), .Y_MIN(YMN), .Y_MAX(YMX), .TICK_DIV(TD), .BIRD_X(BX)
   ) dut (
      .iClock  (iClock),
      .iResetN (iResetN),
      .bus     (bus)
   );

   always #5 iClock = ~iClock;

   int errors = 0;
   int checks = 0;

   // behavioural model state
   int mx[N];
   int my[N];
   bit mv[N];
   int mtimer;
   bit mresp;
   int mscore;

   function automatic int clampy(input int r);
      if (r < YMN) return YMN;
      if (r > YMX) return YMX;
      return r;
   endfunction

   function automatic int get_x(input int i);
      return int'($signed(bus.oPipeX[i*CW +: CW]));
   endfunction

   function automatic int get_y(input int i);
      return int'($signed(bus.oPipeY[i*CW +: CW]));
   endfunction

   function automatic int exp_score();
`ifdef PIPE_SCROLLER_SCORE_EN
      return mscore;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset(input int y0);
      for (int i = 0; i < N; i++) begin
         mx[i] = SW + i * PD;
         my[i] = (i == 0) ? y0 : -1;
         mv[i] = (i == 0);
      end
      mtimer = 0;
      mresp  = 0;
      mscore = 0;
   endtask

   task automatic model_step();
      int st, sp, r, seed, resp;
      int nx[N];
      bit tk;
      st = int'(bus.iState);
      sp = int'(bus.iSpeed);
      r  = int'(bus.iRandomNumber);
      if (st == 0) begin
         model_reset(clampy(r));
      end else if (st == 1) begin
         seed = -1;
         resp = -1;
         for (int i = 0; i < N; i++)
            if (!mv[i] && seed < 0) seed = i;
         if (seed < 0)
            for (int i = 0; i < N; i++)
               if (mx[i] < -PW && resp < 0) resp = i;
         tk     = (mtimer == TD - 1);
         mtimer = tk ? 0 : mtimer + 1;
         for (int i = 0; i < N; i++)
            nx[i] = tk ? mx[i] - sp : mx[i];
         for (int i = 0; i < N; i++)
            if (tk && i != resp && mx[i] >= BX && nx[i] < BX && mscore < 65535)
               mscore++;
         if (resp >= 0) begin
            nx[resp] = nx[(resp + N - 1) % N] + PD;
            my[resp] = clampy(r);
         end
         if (seed >= 0) begin
            my[seed] = clampy(r);
            mv[seed] = 1;
         end
         for (int i = 0; i < N; i++) mx[i] = nx[i];
         mresp = (resp >= 0);
      end else begin
         mresp = 0;
      end
   endtask

   // one clock: model advances with the inputs present at the edge
   task automatic step();
      @(posedge iClock);
      model_step();
      #1;
   endtask

   task automatic run(input int n, input int st, input int sp);
      bus.iState = 2'(st);
      bus.iSpeed = 4'(sp);
      for (int k = 0; k < n; k++) begin
         bus.iRandomNumber = $signed(32'($urandom_range(0, 500)) - 32'sd100);
         step();
      end
   endtask

   task automatic test_reset();
      int ex[N] = '{640, 915, 1190};
      int ey[N] = '{50, -1, -1};
      bus.iState        = 2'd0;
      bus.iSpeed        = 4'd0;
      bus.iRandomNumber = 32'sd7;
      #2 iResetN = 1'b0;
      model_reset(YMN);
      #1;
      for (int i = 0; i < N; i++) begin
         checks++;
         if (get_x(i) !== ex[i] || get_y(i) !== ey[i]) begin
            errors++;
            $display("FAIL reset_xy pipe%0d: got x=%0d y=%0d want x=%0d y=%0d",
                     i, get_x(i), get_y(i), ex[i], ey[i]);
         end
      end
      checks++;
      if (bus.oValid !== 3'b001 || bus.oRespawn !== 1'b0 || bus.oScore !== 16'd0) begin
         errors++;
         $display("FAIL reset_flags: got valid=%b resp=%b score=%0d want 001/0/0",
                  bus.oValid, bus.oRespawn, bus.oScore);
      end
      @(negedge iClock);
      iResetN = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_seeding();
      bus.iState = 2'd0;
      bus.iRandomNumber = 32'sd1000;
      step();
      checks++;
      if (get_y(0) !== 330) begin
         errors++;
         $display("FAIL idle_clamp_hi: got y0=%0d want 330", get_y(0));
      end
      bus.iRandomNumber = -32'sd5;
      step();
      checks++;
      if (get_y(0) !== 50 || bus.oValid !== 3'b001) begin
         errors++;
         $display("FAIL idle_clamp_lo: got y0=%0d valid=%b want 50/001", get_y(0), bus.oValid);
      end
      bus.iState = 2'd1;
      bus.iRandomNumber = 32'sd200;
      step();
      checks++;
      if (get_y(1) !== 200 || bus.oValid !== 3'b011 || get_y(2) !== -1) begin
         errors++;
         $display("FAIL seed1: got y1=%0d y2=%0d valid=%b want 200/-1/011",
                  get_y(1), get_y(2), bus.oValid);
      end
      bus.iRandomNumber = 32'sd400;
      step();
      checks++;
      if (get_y(2) !== 330 || bus.oValid !== 3'b111 || get_y(0) !== 50) begin
         errors++;
         $display("FAIL seed2: got y2=%0d y0=%0d valid=%b want 330/50/111",
                  get_y(2), get_y(0), bus.oValid);
      end
      $display("test_seeding done");
   endtask

   task automatic test_move_pause();
      run(1, 0, 0);
      run(8, 1, 3);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (get_x(i) !== SW + i * PD - 6) begin
            errors++;
            $display("FAIL move8 pipe%0d: got x=%0d want %0d", i, get_x(i), SW + i * PD - 6);
         end
      end
      run(2, 1, 3);
      run(10, 2, 3);
      checks++;
      if (get_x(0) !== 634 || get_x(2) !== 1184 || bus.oRespawn !== 1'b0) begin
         errors++;
         $display("FAIL pause_hold: got x0=%0d x2=%0d resp=%b want 634/1184/0",
                  get_x(0), get_x(2), bus.oRespawn);
      end
      run(1, 1, 3);
      checks++;
      if (get_x(0) !== 634) begin
         errors++;
         $display("FAIL resume_early: got x0=%0d want 634", get_x(0));
      end
      run(1, 1, 3);
      checks++;
      if (get_x(0) !== 631 || get_x(1) !== 906) begin
         errors++;
         $display("FAIL resume_tick: got x0=%0d x1=%0d want 631/906", get_x(0), get_x(1));
      end
      $display("test_move_pause done");
   endtask

   task automatic test_respawn();
      run(1, 0, 0);
      run(46 * TD, 1, 15);
      run(TD, 1, 3);
      checks++;
      if (get_x(0) !== -53 || get_x(2) !== 497 || bus.oRespawn !== 1'b0) begin
         errors++;
         $display("FAIL pre_respawn: got x0=%0d x2=%0d resp=%b want -53/497/0",
                  get_x(0), get_x(2), bus.oRespawn);
      end
      bus.iRandomNumber = 32'sd120;
      step();
      checks++;
      if (get_x(0) !== 772 || get_y(0) !== 120 || bus.oRespawn !== 1'b1 || get_x(1) !== 222) begin
         errors++;
         $display("FAIL respawn: got x0=%0d y0=%0d resp=%b x1=%0d want 772/120/1/222",
                  get_x(0), get_y(0), bus.oRespawn, get_x(1));
      end
      run(1, 1, 3);
      checks++;
      if (bus.oRespawn !== 1'b0) begin
         errors++;
         $display("FAIL respawn_pulse: got resp=%b want 0", bus.oRespawn);
      end
      $display("test_respawn done");
   endtask

   task automatic test_score();
      int want;
      run(1, 0, 0);
      run(35 * TD, 1, 15);
      run(TD, 1, 14);
      checks++;
      if (get_x(0) !== 101 || bus.oScore !== 16'd0) begin
         errors++;
         $display("FAIL score_pre: got x0=%0d score=%0d want 101/0", get_x(0), bus.oScore);
      end
      run(TD, 1, 2);
`ifdef PIPE_SCROLLER_SCORE_EN
      want = 1;
`else
      want = 0;
`endif
      checks++;
      if (get_x(0) !== 99 || int'(bus.oScore) !== want) begin
         errors++;
         $display("FAIL score_cross: got x0=%0d score=%0d want 99/%0d", get_x(0), bus.oScore, want);
      end
      $display("test_score done");
   endtask

   task automatic test_async_reset();
      run(1, 0, 0);
      run(2 + 2 * TD, 1, 9);
      #2 iResetN = 1'b0;
      model_reset(YMN);
      #1;
      checks++;
      if (get_x(0) !== 640 || get_x(1) !== 915 || get_x(2) !== 1190 || get_y(0) !== 50 ||
          get_y(1) !== -1 || bus.oValid !== 3'b001 || bus.oRespawn !== 1'b0 || bus.oScore !== 16'd0) begin
         errors++;
         $display("FAIL async_reset: got x=%0d/%0d/%0d y0=%0d y1=%0d valid=%b want 640/915/1190 50 -1 001",
                  get_x(0), get_x(1), get_x(2), get_y(0), get_y(1), bus.oValid);
      end
      @(negedge iClock);
      iResetN = 1'b1;
      run(TD - 1, 1, 5);
      checks++;
      if (get_x(0) !== 640) begin
         errors++;
         $display("FAIL timer_restart_early: got x0=%0d want 640", get_x(0));
      end
      run(1, 1, 5);
      checks++;
      if (get_x(0) !== 635 || get_x(2) !== 1185) begin
         errors++;
         $display("FAIL timer_restart_tick: got x0=%0d x2=%0d want 635/1185", get_x(0), get_x(2));
      end
      $display("test_async_reset done");
   endtask

   task automatic test_random();
      logic [N-1:0] ev;
      int sel;
      for (int c = 0; c < 1500; c++) begin
         sel = int'($urandom_range(0, 999));
         if (sel < 2)       bus.iState = 2'd0;
         else if (sel < 60) bus.iState = 2'(2 + (sel & 1));
         else               bus.iState = 2'd1;
         bus.iSpeed        = 4'($urandom_range(0, 15));
         bus.iRandomNumber = $signed(32'($urandom_range(0, 600)) - 32'sd150);
         step();
         for (int i = 0; i < N; i++) begin
            ev[i] = mv[i];
            checks++;
            if (get_x(i) !== mx[i] || get_y(i) !== my[i]) begin
               errors++;
               $display("FAIL rand_xy cyc%0d pipe%0d: got x=%0d y=%0d want x=%0d y=%0d",
                        c, i, get_x(i), get_y(i), mx[i], my[i]);
            end
         end
         checks++;
         if (bus.oValid !== ev || bus.oRespawn !== mresp || int'(bus.oScore) !== exp_score()) begin
            errors++;
            $display("FAIL rand_flags cyc%0d: got valid=%b resp=%b score=%0d want %b/%b/%0d",
                     c, bus.oValid, bus.oRespawn, bus.oScore, ev, mresp, exp_score());
         end
      end
      $display("test_random done");
   endtask

   initial begin
      test_reset();
      test_seeding();
      test_move_pause();
      test_respawn();
      test_score();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
